wb_multi_stage: RTL and testbench
=================================

WB_MULTI_STAGE -- requirements
Module: wb_multi_stage

Interface
REQ-001 SHALL take parameter DW, default 32, meaning data word width.
REQ-002 SHALL take parameter RW, default 5, meaning register index width.
REQ-003 SHALL take parameter LANES, default 2, range 1..4, meaning number of write-back lanes (lane LANES-1 is youngest).
REQ-004 SHALL take parameter CNTW, default 32, meaning retire counter width.
REQ-005 SHALL have ports: CLK in 1, clock; nRST in 1, reset.
- One clock, CLK. Reset nRST is asynchronous and active-low.
REQ-006 SHALL have ports: ihit in 1, stage advance; flush in 1, squash the incoming bundle; dhit in 1, data memory response valid; dmemload in DW, load data.
REQ-007 SHALL have per-lane inputs, packed lane-major:
- vld_in: LANES bits.
- regWr_in: LANES bits.
- regSel_in: LANES*2 bits.
- regDst_in: LANES*RW bits.
- nPC_in, ALUOut_in, lui_in: LANES*DW bits each.
- halt_in: 1 bit, bundle halt.
REQ-008 SHALL have outputs:
- WEN: LANES bits, per-lane write enable.
- wsel: LANES*RW bits.
- wdat: LANES*DW bits.
- ld_pend: 1 bit, a latched load is awaiting data.
- halt: 1 bit.
- retired: CNTW bits, count of committed register writes.

Function
REQ-009 SHALL latch all per-lane inputs and halt_in into the stage register on a rising CLK edge when ihit=1; the latch SHALL hold while ihit=0.
REQ-010 SHALL, when ihit=1 and flush=1 together, load all lane valid bits and the latched halt with 0 instead of the inputs.
REQ-011 SHALL ignore flush when ihit=0.
REQ-012 SHALL use this regSel encoding: 0=ALUOut, 1=dmemload (load), 2=nPC, 3=lui.
- Each lane's wdat is the selected latched word.
- A load lane's wdat is its captured load data.
REQ-013 SHALL keep a per-lane ld_ok flag.
- On a dhit cycle, dmemload is captured into the lowest-index valid load lane with ld_ok=0, and that lane's ld_ok is set.
- Only one lane is filled per dhit.
REQ-014 SHALL apply dhit to the bundle being latched when ihit=1 and dhit=1 coincide.
- The lowest new load lane captures dmemload with ld_ok=1.
- The old bundle is discarded.
REQ-015 SHALL ignore dhit when no lane qualifies.
REQ-016 SHALL drive ld_pend=1 iff any valid lane has regSel=1 and ld_ok=0.
REQ-017 SHALL compute per-lane eligibility as: valid & regWr & regDst!=0 & (regSel!=1 | ld_ok) & ~done.
REQ-018 SHALL suppress lane i's WEN when a younger valid lane j>i with regWr=1 has the same regDst.
- The suppressed lane's done flag is set immediately.
- Eligibility of the younger lane is not required for suppression.
REQ-019 SHALL keep a per-lane done flag.
- done is set on the cycle after WEN is asserted, so each latched write asserts WEN for exactly one cycle.
- done is cleared when a new bundle is latched.
REQ-020 SHALL assert WEN combinationally from latched state; wsel equals the latched regDst.
REQ-021 SHALL increment retired by popcount(WEN) each cycle, wrapping modulo 2^CNTW.
REQ-022 SHALL set halt when a latched valid halt bit is seen with ld_pend=0.
- halt is sticky until reset.
- Further ihit after halt is set has no effect on halt.

Reset
REQ-023 SHALL clear on nRST=0, immediately and independent of CLK:
- all valid, ld_ok and done flags;
- latched data;
- WEN, ld_pend, halt and retired, all 0.
REQ-024 SHALL discard an in-flight load on reset, so a dhit arriving after reset release writes nothing.

Verification
REQ-025 Single ALU write: LANES=2.
- Stimulus: lane0 regWr=1, regDst=3, regSel=0, ALUOut=0x12; ihit pulse.
- Response: next cycle WEN=01, wsel0=3, wdat0=0x12 for one cycle; retired=1.
REQ-026 Late load:
- Stimulus: lane1 load to r7; ihit; dhit arrives 3 cycles later with 0xCAFE.
- Response: ld_pend=1 for 3 cycles; then WEN=10, wsel1=7, wdat1=0xCAFE once.
REQ-027 Same-destination collision:
- Stimulus: both lanes write r5 (ALUOut 1 and 2).
- Response: only WEN=10 with wdat1=2; retired increments by 1.
REQ-028 Flush and zero register:
- Stimulus: ihit with flush=1 → Response: no WEN.
- Stimulus: regDst=0 with regWr=1 → Response: no WEN, retired unchanged.
REQ-029 Halt behind load:
- Stimulus: halt_in=1 bundle containing a pending load.
- Response: halt stays 0 until dhit, then 1; it stays 1 through later ihit.
REQ-030 Reset mid-load:
- Stimulus: nRST=0 while ld_pend=1; release; dhit.
- Response: all outputs 0 and no WEN; retired=0.

Source files
------------

// File: rtl/wb_multi_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_multi_stage
// Description : Multi-lane write-back stage with late load fill, same-target
//               write squashing, sticky halt and a committed-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_multi_stage #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int LANES = 2,
  parameter int CNTW  = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ihit,
  input  logic                  flush,
  input  logic                  dhit,
  input  logic [DW-1:0]         dmemload,
  input  logic [LANES-1:0]      vld_in,
  input  logic [LANES-1:0]      regWr_in,
  input  logic [LANES*2-1:0]    regSel_in,
  input  logic [LANES*RW-1:0]   regDst_in,
  input  logic [LANES*DW-1:0]   nPC_in,
  input  logic [LANES*DW-1:0]   ALUOut_in,
  input  logic [LANES*DW-1:0]   lui_in,
  input  logic                  halt_in,
  output logic [LANES-1:0]      WEN,
  output logic [LANES*RW-1:0]   wsel,
  output logic [LANES*DW-1:0]   wdat,
  output logic                  ld_pend,
  output logic                  halt,
  output logic [CNTW-1:0]       retired
);

  localparam logic [1:0] c_SEL_ALU  = 2'd0;
  localparam logic [1:0] c_SEL_LOAD = 2'd1;
  localparam logic [1:0] c_SEL_NPC  = 2'd2;
  localparam logic [1:0] c_SEL_LUI  = 2'd3;

  // Unpacked views of the lane-major input buses
  logic [1:0]    w_regsel_in [LANES];
  logic [RW-1:0] w_regdst_in [LANES];
  logic [DW-1:0] w_npc_in    [LANES];
  logic [DW-1:0] w_alu_in    [LANES];
  logic [DW-1:0] w_lui_in    [LANES];

  // Stage register
  logic [LANES-1:0] r_vld;
  logic [LANES-1:0] r_regwr;
  logic [LANES-1:0] r_ldok;
  logic [LANES-1:0] r_done;
  logic [1:0]       r_regsel [LANES];
  logic [RW-1:0]    r_regdst [LANES];
  logic [DW-1:0]    r_npc    [LANES];
  logic [DW-1:0]    r_alu    [LANES];
  logic [DW-1:0]    r_lui    [LANES];
  logic [DW-1:0]    r_ldata  [LANES];
  logic             r_halt_l;
  logic             r_halt;
  logic [CNTW-1:0]  r_retired;

  logic [LANES-1:0] w_elig;
  logic [LANES-1:0] w_shadow;
  logic [LANES-1:0] w_wen;
  logic [LANES-1:0] w_fill_old;
  logic [LANES-1:0] w_fill_new;
  logic [LANES-1:0] w_ld_wait;
  logic [DW-1:0]    w_wdat [LANES];
  logic [CNTW-1:0]  w_pop;
  logic             w_found_old;
  logic             w_found_new;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign w_regsel_in[g]     = regSel_in[g*2 +: 2];
      assign w_regdst_in[g]     = regDst_in[g*RW +: RW];
      assign w_npc_in[g]        = nPC_in[g*DW +: DW];
      assign w_alu_in[g]        = ALUOut_in[g*DW +: DW];
      assign w_lui_in[g]        = lui_in[g*DW +: DW];
      assign wsel[g*RW +: RW]   = r_regdst[g];
      assign wdat[g*DW +: DW]   = w_wdat[g];
    end
  endgenerate

  // Per-lane eligibility, younger-lane squashing and result selection
  always_comb begin
    w_elig    = '0;
    w_shadow  = '0;
    w_ld_wait = '0;
    for (int i = 0; i < LANES; i++) begin
      w_wdat[i]    = r_alu[i];
      w_ld_wait[i] = r_vld[i] & (r_regsel[i] == c_SEL_LOAD) & ~r_ldok[i];
      w_elig[i]    = r_vld[i] & r_regwr[i] & (r_regdst[i] != '0) &
                     ((r_regsel[i] != c_SEL_LOAD) | r_ldok[i]) & ~r_done[i];
      for (int j = 0; j < LANES; j++) begin
        if (j > i && r_vld[j] && r_regwr[j] && (r_regdst[j] == r_regdst[i]))
          w_shadow[i] = 1'b1;
      end
      case (r_regsel[i])
        c_SEL_ALU:  w_wdat[i] = r_alu[i];
        c_SEL_LOAD: w_wdat[i] = r_ldata[i];
        c_SEL_NPC:  w_wdat[i] = r_npc[i];
        c_SEL_LUI:  w_wdat[i] = r_lui[i];
        default:    w_wdat[i] = r_alu[i];
      endcase
    end
    w_wen = w_elig & ~w_shadow;
  end

  // One load lane filled per dhit: lowest waiting lane, either held or incoming
  always_comb begin
    w_fill_old  = '0;
    w_fill_new  = '0;
    w_found_old = 1'b0;
    w_found_new = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!w_found_old && dhit && w_ld_wait[i]) begin
        w_fill_old[i] = 1'b1;
        w_found_old   = 1'b1;
      end
      if (!w_found_new && dhit && !flush && vld_in[i] &&
          (w_regsel_in[i] == c_SEL_LOAD)) begin
        w_fill_new[i] = 1'b1;
        w_found_new   = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++)
      w_pop = w_pop + CNTW'(w_wen[i]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_vld     <= '0;
      r_regwr   <= '0;
      r_ldok    <= '0;
      r_done    <= '0;
      r_halt_l  <= 1'b0;
      r_halt    <= 1'b0;
      r_retired <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_regsel[i] <= '0;
        r_regdst[i] <= '0;
        r_npc[i]    <= '0;
        r_alu[i]    <= '0;
        r_lui[i]    <= '0;
        r_ldata[i]  <= '0;
      end
    end else begin
      r_retired <= r_retired + w_pop;
      r_halt    <= r_halt | (r_halt_l & ~(|w_ld_wait));
      if (ihit) begin
        r_vld    <= flush ? '0 : vld_in;
        r_regwr  <= regWr_in;
        r_halt_l <= halt_in & ~flush;
        r_done   <= '0;
        r_ldok   <= w_fill_new;
        for (int i = 0; i < LANES; i++) begin
          r_regsel[i] <= w_regsel_in[i];
          r_regdst[i] <= w_regdst_in[i];
          r_npc[i]    <= w_npc_in[i];
          r_alu[i]    <= w_alu_in[i];
          r_lui[i]    <= w_lui_in[i];
          r_ldata[i]  <= w_fill_new[i] ? dmemload : '0;
        end
      end else begin
        // Squashed lanes retire silently alongside lanes that just wrote
        r_done <= r_done | w_wen | w_shadow;
        r_ldok <= r_ldok | w_fill_old;
        for (int i = 0; i < LANES; i++) begin
          if (w_fill_old[i])
            r_ldata[i] <= dmemload;
        end
      end
    end
  end

  assign WEN     = w_wen;
  assign ld_pend = |w_ld_wait;
  assign halt    = r_halt;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_multi_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_multi_stage
// Description : Directed self-checking bench for wb_multi_stage (LANES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_multi_stage;

  localparam int DW = 32, RW = 5, LANES = 2, CNTW = 32;

  logic                CLK = 1'b0;
  logic                nRST;
  logic                ihit, flush, dhit, halt_in;
  logic [DW-1:0]       dmemload;
  logic [LANES-1:0]    vld_in, regWr_in;
  logic [LANES*2-1:0]  regSel_in;
  logic [LANES*RW-1:0] regDst_in;
  logic [LANES*DW-1:0] nPC_in, ALUOut_in, lui_in;
  logic [LANES-1:0]    WEN;
  logic [LANES*RW-1:0] wsel;
  logic [LANES*DW-1:0] wdat;
  logic                ld_pend, halt;
  logic [CNTW-1:0]     retired;

  int checks   = 0;
  int failures = 0;

  wb_multi_stage #(.DW(DW), .RW(RW), .LANES(LANES), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .dhit(dhit),
    .dmemload(dmemload), .vld_in(vld_in), .regWr_in(regWr_in),
    .regSel_in(regSel_in), .regDst_in(regDst_in), .nPC_in(nPC_in),
    .ALUOut_in(ALUOut_in), .lui_in(lui_in), .halt_in(halt_in),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .ld_pend(ld_pend),
    .halt(halt), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ihit = 0; flush = 0; dhit = 0; halt_in = 0; dmemload = '0;
    vld_in = '0; regWr_in = '0; regSel_in = '0; regDst_in = '0;
    nPC_in = '0; ALUOut_in = '0; lui_in = '0;
  endtask

  task automatic lane(input int l, input logic [1:0] sel, input logic [RW-1:0] dst,
                      input logic [DW-1:0] alu, input logic [DW-1:0] npc,
                      input logic [DW-1:0] lui);
    vld_in[l]             = 1'b1;
    regWr_in[l]           = 1'b1;
    regSel_in[l*2 +: 2]   = sel;
    regDst_in[l*RW +: RW] = dst;
    ALUOut_in[l*DW +: DW] = alu;
    nPC_in[l*DW +: DW]    = npc;
    lui_in[l*DW +: DW]    = lui;
  endtask

  initial begin
    clr();
    nRST = 1'b0;
    #2;
    check("rst_wen", 64'(WEN), 64'h0);
    check("rst_ldpend", 64'(ld_pend), 64'h0);
    check("rst_halt", 64'(halt), 64'h0);
    check("rst_retired", 64'(retired), 64'h0);
    check("rst_wdat", wdat, 64'h0);
    #1 nRST = 1'b1;
    tick();

    // Single ALU write
    lane(0, 2'd0, 5'd3, 32'h12, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("alu_wen", 64'(WEN), 64'h1);
    check("alu_wsel0", 64'(wsel[4:0]), 64'd3);
    check("alu_wdat0", 64'(wdat[31:0]), 64'h12);
    tick();
    check("alu_wen_once", 64'(WEN), 64'h0);
    check("alu_retired", 64'(retired), 64'd1);

    // Late load on lane1
    lane(1, 2'd1, 5'd7, 32'h0, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("ld_pend_c1", 64'(ld_pend), 64'h1);
    check("ld_wen_c1", 64'(WEN), 64'h0);
    tick();
    check("ld_pend_c2", 64'(ld_pend), 64'h1);
    tick();
    check("ld_pend_c3", 64'(ld_pend), 64'h1);
    dhit = 1; dmemload = 32'hCAFE;
    tick(); clr();
    check("ld_pend_done", 64'(ld_pend), 64'h0);
    check("ld_wen", 64'(WEN), 64'h2);
    check("ld_wsel1", 64'(wsel[9:5]), 64'd7);
    check("ld_wdat1", 64'(wdat[63:32]), 64'hCAFE);
    tick();
    check("ld_wen_once", 64'(WEN), 64'h0);
    check("ld_retired", 64'(retired), 64'd2);

    // Same destination in both lanes: younger wins
    lane(0, 2'd0, 5'd5, 32'd1, 32'h0, 32'h0);
    lane(1, 2'd0, 5'd5, 32'd2, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("col_wen", 64'(WEN), 64'h2);
    check("col_wdat1", 64'(wdat[63:32]), 64'd2);
    tick();
    check("col_wen_after", 64'(WEN), 64'h0);
    check("col_retired", 64'(retired), 64'd3);

    // Flushed bundle
    lane(0, 2'd0, 5'd4, 32'h44, 32'h0, 32'h0);
    lane(1, 2'd0, 5'd6, 32'h66, 32'h0, 32'h0); ihit = 1; flush = 1;
    tick(); clr();
    check("flush_wen", 64'(WEN), 64'h0);
    tick();
    check("flush_retired", 64'(retired), 64'd3);

    // Write to r0
    lane(0, 2'd0, 5'd0, 32'h99, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("r0_wen", 64'(WEN), 64'h0);
    tick();
    check("r0_retired", 64'(retired), 64'd3);

    // nPC and lui selections
    lane(0, 2'd2, 5'd1, 32'h0, 32'h100, 32'h0);
    lane(1, 2'd3, 5'd2, 32'h0, 32'h0, 32'hABCD0000); ihit = 1;
    tick(); clr();
    check("sel_wen", 64'(WEN), 64'h3);
    check("sel_wdat", wdat, 64'hABCD0000_00000100);
    tick();
    check("sel_retired", 64'(retired), 64'd5);

    // dhit coinciding with ihit fills the incoming load
    lane(0, 2'd1, 5'd9, 32'h0, 32'h0, 32'h0); ihit = 1; dhit = 1; dmemload = 32'h55;
    tick(); clr();
    check("co_ldpend", 64'(ld_pend), 64'h0);
    check("co_wen", 64'(WEN), 64'h1);
    check("co_wdat0", 64'(wdat[31:0]), 64'h55);
    tick();
    // Stray dhit with nothing waiting
    dhit = 1; dmemload = 32'hDEAD;
    tick(); clr();
    check("stray_wen", 64'(WEN), 64'h0);
    check("stray_retired", 64'(retired), 64'd6);

    // Two loads filled in lane order
    lane(0, 2'd1, 5'd10, 32'h0, 32'h0, 32'h0);
    lane(1, 2'd1, 5'd11, 32'h0, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("two_ldpend", 64'(ld_pend), 64'h1);
    dhit = 1; dmemload = 32'hA;
    tick();
    check("two_wen_a", 64'(WEN), 64'h1);
    check("two_wdat0", 64'(wdat[31:0]), 64'hA);
    check("two_ldpend_a", 64'(ld_pend), 64'h1);
    dmemload = 32'hB;
    tick(); clr();
    check("two_wen_b", 64'(WEN), 64'h2);
    check("two_wdat1", 64'(wdat[63:32]), 64'hB);
    check("two_ldpend_b", 64'(ld_pend), 64'h0);
    tick();
    check("two_retired", 64'(retired), 64'd8);

    // Halt waits for the load
    lane(0, 2'd1, 5'd12, 32'h0, 32'h0, 32'h0); halt_in = 1; ihit = 1;
    tick(); clr();
    check("hl_halt_c1", 64'(halt), 64'h0);
    tick();
    check("hl_halt_c2", 64'(halt), 64'h0);
    dhit = 1; dmemload = 32'h77;
    tick(); clr();
    check("hl_wen", 64'(WEN), 64'h1);
    tick();
    check("hl_halt_set", 64'(halt), 64'h1);
    ihit = 1;
    tick(); clr();
    tick();
    check("hl_halt_sticky", 64'(halt), 64'h1);
    check("hl_retired", 64'(retired), 64'd9);

    // Reset while a load is outstanding
    lane(1, 2'd1, 5'd13, 32'h0, 32'h0, 32'h0); ihit = 1;
    tick(); clr();
    check("rl_ldpend", 64'(ld_pend), 64'h1);
    nRST = 1'b0;
    #1;
    check("rl_async_ldpend", 64'(ld_pend), 64'h0);
    check("rl_async_halt", 64'(halt), 64'h0);
    check("rl_async_retired", 64'(retired), 64'h0);
    check("rl_async_wdat", wdat, 64'h0);
    #1 nRST = 1'b1;
    dhit = 1; dmemload = 32'h99;
    tick(); clr();
    check("rl_wen", 64'(WEN), 64'h0);
    check("rl_ldpend_after", 64'(ld_pend), 64'h0);
    tick();
    check("rl_retired", 64'(retired), 64'h0);
    check("rl_halt", 64'(halt), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
